// File: rtl/write_back_stage.sv
// Write-back stage: latches memory-stage results, waits for load data, drives the register-file write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNTER_EN.
module write_back_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            validIn,
  output logic            readyOut,
  input  logic [XLEN-1:0] aluResult,
  input  logic [XLEN-1:0] pcPlus4,
  input  logic [4:0]      destinationRegisterIndex,
  input  logic            regWrite,
  input  logic [1:0]      writeBackSelect,
  input  logic [2:0]      loadFunct3,
  input  logic            memResponseValid,
  input  logic [XLEN-1:0] memResponseData,
  output logic [XLEN-1:0] writeBackData,
  output logic [4:0]      writeRegisterIndex,
  output logic            shouldWriteToRegister,
  output logic [63:0]     retiredCount
);

  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    WAIT_MEM = 2'b01,
    COMMIT   = 2'b10
  } stateT;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_ALU2 = 2'b11
  } wbSelT;

  stateT           state;
  stateT           nextState;
  stateT           captureTarget;
  logic            capture;
  logic            commit;

  logic [XLEN-1:0] aluQ;
  logic [XLEN-1:0] pcQ;
  logic [4:0]      rdQ;
  logic            regWriteQ;
  wbSelT           selQ;
  logic [2:0]      funct3Q;
  logic [XLEN-1:0] loadQ;

  logic [XLEN-1:0] dataHold;
  logic [4:0]      indexHold;

  logic [7:0]      loadByte;
  logic [15:0]     loadHalf;
  logic [XLEN-1:0] loadExt;
  logic [XLEN-1:0] selected;

  always_comb begin
    readyOut      = (state != WAIT_MEM);
    capture       = validIn && readyOut;
    commit        = (state == COMMIT);
    captureTarget = COMMIT;
    if ((wbSelT'(writeBackSelect) == SEL_LOAD) && !memResponseValid) begin
      captureTarget = WAIT_MEM;
    end
    nextState = state;
    case (state)
      EMPTY:    if (validIn) nextState = captureTarget;
      WAIT_MEM: if (memResponseValid) nextState = COMMIT;
      COMMIT:   nextState = validIn ? captureTarget : EMPTY;
      default:  nextState = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // Stage register; load data is taken either with the capture or later in WAIT_MEM.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      aluQ      <= '0;
      pcQ       <= '0;
      rdQ       <= '0;
      regWriteQ <= 1'b0;
      selQ      <= SEL_ALU;
      funct3Q   <= '0;
      loadQ     <= '0;
    end else begin
      if (capture) begin
        aluQ      <= aluResult;
        pcQ       <= pcPlus4;
        rdQ       <= destinationRegisterIndex;
        regWriteQ <= regWrite;
        selQ      <= wbSelT'(writeBackSelect);
        funct3Q   <= loadFunct3;
        if ((wbSelT'(writeBackSelect) == SEL_LOAD) && memResponseValid) begin
          loadQ <= memResponseData;
        end
      end else if ((state == WAIT_MEM) && memResponseValid) begin
        loadQ <= memResponseData;
      end
    end
  end

  always_comb begin
    case (aluQ[1:0])
      2'd0:    loadByte = loadQ[7:0];
      2'd1:    loadByte = loadQ[15:8];
      2'd2:    loadByte = loadQ[23:16];
      default: loadByte = loadQ[31:24];
    endcase
    loadHalf = aluQ[1] ? loadQ[31:16] : loadQ[15:0];
    case (funct3Q)
      3'b000:  loadExt = {{(XLEN-8){loadByte[7]}}, loadByte};
      3'b001:  loadExt = {{(XLEN-16){loadHalf[15]}}, loadHalf};
      3'b100:  loadExt = {{(XLEN-8){1'b0}}, loadByte};
      3'b101:  loadExt = {{(XLEN-16){1'b0}}, loadHalf};
      default: loadExt = loadQ;
    endcase
    case (selQ)
      SEL_LOAD: selected = loadExt;
      SEL_PC4:  selected = pcQ;
      default:  selected = aluQ;
    endcase
  end

  // Hold registers keep the last committed value visible after the stage register is reused.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dataHold  <= '0;
      indexHold <= '0;
    end else if (commit) begin
      dataHold  <= selected;
      indexHold <= rdQ;
    end
  end

  always_comb begin
    writeBackData         = commit ? selected : dataHold;
    writeRegisterIndex    = commit ? rdQ : indexHold;
    shouldWriteToRegister = commit && regWriteQ && (rdQ != 5'd0);
  end

`ifdef WB_RETIRE_COUNTER_EN
  logic [63:0] retiredQ;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      retiredQ <= '0;
    end else if (commit) begin
      retiredQ <= retiredQ + 64'd1;
    end
  end

  assign retiredCount = retiredQ;
`else
  assign retiredCount = '0;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Directed testbench for write_back_stage; checks handshake, load extraction, write port and reset.
module tb_write_back_stage;

  logic        clk;
  logic        resetN;
  logic        validIn;
  logic        readyOut;
  logic [31:0] aluResult;
  logic [31:0] pcPlus4;
  logic [4:0]  destinationRegisterIndex;
  logic        regWrite;
  logic [1:0]  writeBackSelect;
  logic [2:0]  loadFunct3;
  logic        memResponseValid;
  logic [31:0] memResponseData;
  logic [31:0] writeBackData;
  logic [4:0]  writeRegisterIndex;
  logic        shouldWriteToRegister;
  logic [63:0] retiredCount;

  int tests;
  int fails;

  write_back_stage #(.XLEN(32)) dut (
    .clk                     (clk),
    .resetN                  (resetN),
    .validIn                 (validIn),
    .readyOut                (readyOut),
    .aluResult               (aluResult),
    .pcPlus4                 (pcPlus4),
    .destinationRegisterIndex(destinationRegisterIndex),
    .regWrite                (regWrite),
    .writeBackSelect         (writeBackSelect),
    .loadFunct3              (loadFunct3),
    .memResponseValid        (memResponseValid),
    .memResponseData         (memResponseData),
    .writeBackData           (writeBackData),
    .writeRegisterIndex      (writeRegisterIndex),
    .shouldWriteToRegister   (shouldWriteToRegister),
    .retiredCount            (retiredCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIns(input logic v, input logic [31:0] alu, input logic [31:0] pc,
                        input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                        input logic [2:0] f3, input logic mrv, input logic [31:0] md);
    validIn                  = v;
    aluResult                = alu;
    pcPlus4                  = pc;
    destinationRegisterIndex = rd;
    regWrite                 = rw;
    writeBackSelect          = sel;
    loadFunct3               = f3;
    memResponseValid         = mrv;
    memResponseData          = md;
  endtask

  task automatic checkWrite(input string tag, input logic sw, input logic [4:0] idx, input logic [31:0] data);
    check({tag, ".we"}, {63'd0, shouldWriteToRegister}, {63'd0, sw});
    check({tag, ".idx"}, {59'd0, writeRegisterIndex}, {59'd0, idx});
    check({tag, ".data"}, {32'd0, writeBackData}, {32'd0, data});
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    resetN = 1'b0;
    setIns(0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkWrite("reset", 0, 0, 32'h0);
    check("reset.ready", {63'd0, readyOut}, 64'd1);
    check("reset.count", retiredCount, 64'd0);
    resetN = 1'b1;

    // Single ALU instruction
    setIns(1, 32'h0000_002A, 32'h0, 5'd5, 1, 2'b00, 3'b000, 0, 0);
    step();
    checkWrite("alu", 1, 5'd5, 32'h0000_002A);
    validIn = 1'b0;
    step();
    checkWrite("alu.after", 0, 5'd5, 32'h0000_002A);

    // Back-to-back ALU writes
    setIns(1, 32'h11, 32'h0, 5'd1, 1, 2'b00, 3'b000, 0, 0);
    step();
    checkWrite("b2b.1", 1, 5'd1, 32'h11);
    check("b2b.ready1", {63'd0, readyOut}, 64'd1);
    setIns(1, 32'h22, 32'h0, 5'd2, 1, 2'b00, 3'b000, 0, 0);
    step();
    checkWrite("b2b.2", 1, 5'd2, 32'h22);
    check("b2b.ready2", {63'd0, readyOut}, 64'd1);
    setIns(1, 32'h33, 32'h0, 5'd3, 1, 2'b11, 3'b000, 0, 0);
    step();
    checkWrite("b2b.3", 1, 5'd3, 32'h33);
    validIn = 1'b0;
    step();
    check("b2b.idle", {63'd0, shouldWriteToRegister}, 64'd0);

    // LB offset 3, response three cycles after capture
    setIns(1, 32'h0000_1003, 32'h0, 5'd7, 1, 2'b01, 3'b000, 0, 32'hDEAD_BEEF);
    step();
    validIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("lb.wait.ready", {63'd0, readyOut}, 64'd0);
      check("lb.wait.we", {63'd0, shouldWriteToRegister}, 64'd0);
      if (i < 2) step();
    end
    memResponseValid = 1'b1;
    memResponseData  = 32'h80FF_FF7F;
    step();
    memResponseValid = 1'b0;
    checkWrite("lb", 1, 5'd7, 32'hFFFF_FF80);
    check("lb.ready", {63'd0, readyOut}, 64'd1);
    step();

    // LBU same access, response in capture cycle
    setIns(1, 32'h0000_1003, 32'h0, 5'd8, 1, 2'b01, 3'b100, 1, 32'h80FF_FF7F);
    step();
    checkWrite("lbu", 1, 5'd8, 32'h0000_0080);

    // Back-to-back loads with response in the capture cycle
    setIns(1, 32'h0000_2002, 32'h0, 5'd9, 1, 2'b01, 3'b001, 1, 32'h8001_1234);
    step();
    checkWrite("lh", 1, 5'd9, 32'hFFFF_8001);
    loadFunct3 = 3'b101;
    step();
    checkWrite("lhu", 1, 5'd9, 32'h0000_8001);
    aluResult  = 32'h0000_2000;
    loadFunct3 = 3'b010;
    step();
    checkWrite("lw", 1, 5'd9, 32'h8001_1234);
    loadFunct3 = 3'b000;
    step();
    checkWrite("lb.off0", 1, 5'd9, 32'h0000_0034);
    aluResult  = 32'h0000_2003;
    loadFunct3 = 3'b001;
    step();
    checkWrite("lh.off3", 1, 5'd9, 32'hFFFF_8001);
    loadFunct3 = 3'b011;
    step();
    checkWrite("ld011", 1, 5'd9, 32'h8001_1234);

    // JAL link and x0 destination
    setIns(1, 32'h0000_DEAD, 32'h0000_0108, 5'd1, 1, 2'b10, 3'b000, 0, 0);
    step();
    checkWrite("jal", 1, 5'd1, 32'h0000_0108);
    destinationRegisterIndex = 5'd0;
    step();
    checkWrite("jal.x0", 0, 5'd0, 32'h0000_0108);
    setIns(1, 32'h0000_0055, 32'h0, 5'd4, 0, 2'b00, 3'b000, 0, 0);
    step();
    checkWrite("nowrite", 0, 5'd4, 32'h0000_0055);
    setIns(0, 32'h0, 32'h0, 5'd0, 0, 2'b00, 3'b000, 1, 32'h1234_5678);
    step();
    check("stale.empty.we", {63'd0, shouldWriteToRegister}, 64'd0);
    memResponseValid = 1'b0;

    // Reset while waiting on a load, then a stale response
    setIns(1, 32'h0000_3000, 32'h0, 5'd6, 1, 2'b01, 3'b010, 0, 0);
    step();
    validIn = 1'b0;
    check("rst.wait.ready", {63'd0, readyOut}, 64'd0);
    resetN = 1'b0;
    #1;
    check("rst.async.ready", {63'd0, readyOut}, 64'd1);
    checkWrite("rst.async", 0, 5'd0, 32'h0);
    #2;
    resetN = 1'b1;
    setIns(0, 32'h0, 32'h0, 5'd0, 0, 2'b00, 3'b000, 1, 32'hCAFE_F00D);
    step();
    memResponseValid = 1'b0;
    check("stale.we", {63'd0, shouldWriteToRegister}, 64'd0);
    check("stale.ready", {63'd0, readyOut}, 64'd1);
    step();
    checkWrite("stale.after", 0, 5'd0, 32'h0);

    // Five retirements, including one rd=x0 and one regWrite=0
    setIns(1, 32'h1, 32'h0, 5'd1, 1, 2'b00, 3'b000, 0, 0);
    step();
    destinationRegisterIndex = 5'd0;
    step();
    regWrite = 1'b0;
    destinationRegisterIndex = 5'd2;
    step();
    regWrite = 1'b1;
    step();
    step();
    validIn = 1'b0;
    step();
`ifdef WB_RETIRE_COUNTER_EN
    check("retired", retiredCount, 64'd5);
`else
    check("retired.off", retiredCount, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
Final pipeline stage of the RV32I core, and the producer side of the register-file write port that the decode stage reads through.
- Latches completed instructions from the memory stage over a valid/ready handshake.
- Waits for a variable-latency load response when the instruction is a load.
- Extracts and extends load data, and selects the write-back value.
- Drives the register-file write port for exactly one cycle per retired instruction.

Parameters:
XLEN, 32, datapath width (only 32 is supported)

Ports:
clk  input  1  clock; all state updates on the rising edge
resetN  input  1  asynchronous, active-low reset
validIn  input  1  memory stage presents an instruction
readyOut  output  1  stage accepts an instruction this cycle
aluResult  input  32  ALU result; also the load address
pcPlus4  input  32  link value for JAL/JALR
destinationRegisterIndex  input  5  rd
regWrite  input  1  instruction writes rd
writeBackSelect  input  2  00 ALU, 01 LOAD, 10 PC+4, 11 ALU
loadFunct3  input  3  load width and sign
memResponseValid  input  1  load data valid
memResponseData  input  32  aligned 32-bit word from data memory
writeBackData  output  32  data to the register file
writeRegisterIndex  output  5  rd to the register file
shouldWriteToRegister  output  1  register-file write enable
retiredCount  output  64  retired-instruction counter (see Optional Feature)

Behaviour:
- State machine states: EMPTY, WAIT_MEM, COMMIT. Reset enters EMPTY.
- Reset values: writeBackData=0, writeRegisterIndex=0, shouldWriteToRegister=0, retiredCount=0, all internal registers cleared.
- readyOut = 1 in EMPTY and COMMIT; readyOut = 0 in WAIT_MEM. It is combinational from state.
- Capture: the instruction is taken on a rising edge where validIn && readyOut. All input fields are latched into the stage register.
  - Capture with select != LOAD: next state COMMIT.
  - Capture with select == LOAD and memResponseValid in the same cycle: latch memResponseData; next state COMMIT.
  - Capture with select == LOAD and no response: next state WAIT_MEM.
- WAIT_MEM: on memResponseValid, latch memResponseData and go to COMMIT. Otherwise hold indefinitely (no timeout).
- COMMIT (lasts exactly one cycle):
  - shouldWriteToRegister = latched regWrite && (latched rd != 0).
  - writeRegisterIndex = latched rd.
  - writeBackData = selected value.
  - Next state: follows the capture rules above if validIn; otherwise EMPTY.
- Outside COMMIT: shouldWriteToRegister = 0. writeRegisterIndex and writeBackData hold their last values.
- Outputs are driven from registered state only, with no combinational path from inputs.
- Latency and throughput:
  - Non-loads, and loads whose response arrives in the capture cycle: written in the cycle after capture.
  - Other loads: written in the cycle after memResponseValid.
  - Back-to-back non-loads: one write per cycle.
- Load extraction uses byte offset = latched aluResult[1:0]:
  - 000 LB: sign-extend byte[offset].
  - 001 LH: sign-extend halfword[offset[1]].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte[offset].
  - 101 LHU: zero-extend halfword[offset[1]].
  - 011, 110, 111: full word.
  - Misalignment is not checked; offset[0] is ignored for halfwords.
- rd = x0: the instruction retires normally, but shouldWriteToRegister stays 0.
- memResponseValid in EMPTY or COMMIT without a load being captured that cycle is ignored.
- resetN deasserted mid-operation (any state): return to EMPTY immediately. Any pending load is discarded; a later stale response is ignored.

Optional Feature:
WB_RETIRE_COUNTER_EN
- Defined: retiredCount is a 64-bit counter.
  - Increments by 1 in every COMMIT cycle, including regWrite=0 and rd=x0 instructions.
  - Wraps from 2^64-1 to 0.
  - Cleared by reset.
- Not defined: retiredCount is tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset, then one ALU instruction (aluResult=0x0000002A, rd=5, regWrite=1, select=00) -> the next cycle gives shouldWrite=1, index=5, data=0x2A; shouldWrite=0 the cycle after.
- Back-to-back ALU to rd=1,2,3 with validIn held high -> three consecutive write cycles; readyOut stays 1.
- LB with aluResult offset 3 and memResponseData=0x80FF_FF7F, response arriving 3 cycles after capture -> readyOut=0 for those 3 cycles; then data=0xFFFFFF80. The same access as LBU gives 0x00000080.
- LH offset 2 on 0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001; LW offset 0 -> 0x80011234, with the response in the capture cycle (1-cycle latency).
- JAL with select=10, pcPlus4=0x00000108, rd=1 -> data=0x108. An identical instruction with rd=0 -> shouldWrite stays 0.
- resetN pulsed low while in WAIT_MEM, followed by a stale memResponseValid -> no write occurs and readyOut=1. With WB_RETIRE_COUNTER_EN defined, after five retirements and no reset, retiredCount=5.
